// File: rtl/arp_responder.sv
`default_nettype none
// ============================================================================
// Module      : arp_responder
// Description : Answers Ethernet ARP requests for MY_IP received on a GMII
//               receive path and sends the ARP reply on GMII transmit.
//               Also counts requests, replies, busy drops and FCS errors.
// Ports       : clock          - single clock, rising edge
//               reset_n        - asynchronous active-low reset
//               rx_dv/rx_data  - GMII receive valid / byte
//               tx_en/tx_data  - GMII transmit enable / byte (0 when idle)
//               busy           - reply accepted and not yet through IFG
//               req_count      - valid ARP requests for MY_IP (wraps)
//               reply_count    - replies fully transmitted (wraps)
//               drop_count     - valid requests dropped while busy (wraps)
//               crc_err_count  - frames >= 64 bytes with bad FCS (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module arp_responder #(
  parameter logic [47:0] MY_MAC     = 48'h00301ba0a48f,
  parameter logic [31:0] MY_IP      = 32'h0a001563,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [15:0] req_count,
  output logic [15:0] reply_count,
  output logic [15:0] drop_count,
  output logic [15:0] crc_err_count
);

  // Register value of the reflected (LSB-first) CRC after a frame plus its
  // own FCS has been shifted in; bit-reversed form of 0xC704DD7B.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] K_MAX       = 11'd2047;
  localparam logic [7:0]  IFG_LAST    = 8'(IFG_CYCLES);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Byte idx of a MAC address in wire order (0 = most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Receive side
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_HUNT, RX_BODY, RX_DROP} rx_state_t;

  rx_state_t   rx_state, rx_state_nx;
  logic [10:0] rx_k;
  logic [31:0] rx_crc;
  logic        bcast_ok, mymac_ok, fld_ok;
  logic [47:0] rx_sha;
  logic [31:0] rx_spa;

  logic        rx_start, rx_byte, rx_end;
  logic        fix_care;
  logic [7:0]  fix_val;
  logic        fcs_good, long_frame, arp_hit;
  logic        req_ok, accept, drop, crc_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_HUNT;
    else          rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_start    = 1'b0;
    rx_byte     = 1'b0;
    rx_end      = 1'b0;
    case (rx_state)
      RX_HUNT: begin
        if (rx_dv) begin
          if (rx_data == 8'hD5) begin
            rx_state_nx = RX_BODY;
            rx_start    = 1'b1;
          end else if (rx_data != 8'h55) begin
            rx_state_nx = RX_DROP;
          end
        end
      end
      RX_BODY: begin
        if (rx_dv) begin
          rx_byte = 1'b1;
        end else begin
          rx_end      = 1'b1;
          rx_state_nx = RX_HUNT;
        end
      end
      RX_DROP: begin
        if (!rx_dv) rx_state_nx = RX_HUNT;
      end
      default: rx_state_nx = RX_HUNT;
    endcase
  end

  // Fixed header bytes that must match exactly (ARP request for MY_IP).
  always_comb begin
    fix_care = 1'b1;
    fix_val  = 8'h00;
    case (rx_k)
      11'd12:  fix_val = 8'h08;
      11'd13:  fix_val = 8'h06;
      11'd14:  fix_val = 8'h00;
      11'd15:  fix_val = 8'h01;
      11'd16:  fix_val = 8'h08;
      11'd17:  fix_val = 8'h00;
      11'd18:  fix_val = 8'h06;
      11'd19:  fix_val = 8'h04;
      11'd20:  fix_val = 8'h00;
      11'd21:  fix_val = 8'h01;
      11'd38:  fix_val = MY_IP[31:24];
      11'd39:  fix_val = MY_IP[23:16];
      11'd40:  fix_val = MY_IP[15:8];
      11'd41:  fix_val = MY_IP[7:0];
      default: fix_care = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_k     <= '0;
      rx_crc   <= '1;
      bcast_ok <= 1'b0;
      mymac_ok <= 1'b0;
      fld_ok   <= 1'b0;
      rx_sha   <= '0;
      rx_spa   <= '0;
    end else if (rx_start) begin
      rx_k     <= '0;
      rx_crc   <= '1;
      bcast_ok <= 1'b1;
      mymac_ok <= 1'b1;
      fld_ok   <= 1'b1;
    end else if (rx_byte) begin
      rx_crc <= crc32_byte(rx_crc, rx_data);
      if (rx_k != K_MAX) rx_k <= rx_k + 11'd1;
      if (rx_k < 11'd6) begin
        bcast_ok <= bcast_ok & (rx_data == 8'hFF);
        mymac_ok <= mymac_ok & (rx_data == mac_byte(MY_MAC, rx_k[2:0]));
      end
      if (fix_care && (rx_data != fix_val)) fld_ok <= 1'b0;
      if (rx_k >= 11'd22 && rx_k <= 11'd27) rx_sha <= {rx_sha[39:0], rx_data};
      if (rx_k >= 11'd28 && rx_k <= 11'd31) rx_spa <= {rx_spa[23:0], rx_data};
    end
  end

  // End-of-frame classification, evaluated on the first rx_dv=0 cycle.
  assign fcs_good   = (rx_crc == CRC_RESIDUE);
  assign long_frame = (rx_k >= 11'd64);
  assign arp_hit    = fld_ok & (bcast_ok | mymac_ok);
  assign crc_err    = rx_end & long_frame & ~fcs_good;
  assign req_ok     = rx_end & long_frame & fcs_good & arp_hit;
  assign accept     = req_ok & ~busy;
  assign drop       = req_ok & busy;

  // --------------------------------------------------------------------------
  // Transmit side
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_FRAME, TX_FCS, TX_IFG} tx_state_t;

  tx_state_t   tx_state, tx_state_nx;
  logic [7:0]  tx_cnt, tx_cnt_nx;
  logic [47:0] tx_mac;
  logic [31:0] tx_ip;
  logic [31:0] tx_crc;
  logic        byte_en;
  logic [7:0]  byte_val;
  logic        tx_done;
  logic [479:0] frame_vec;
  logic [5:0]  frame_rev;

  // The full 60-byte reply, first byte in the top bits.
  assign frame_vec = {tx_mac, MY_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                      16'h0002, MY_MAC, MY_IP, tx_mac, tx_ip, 144'h0};
  assign frame_rev = 6'd59 - tx_cnt[5:0];

  // Busy spans accept through the last IFG cycle, so it is just "not idle".
  assign busy = (tx_state != TX_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    byte_en     = 1'b0;
    byte_val    = 8'h00;
    tx_done     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (accept) begin
          tx_state_nx = TX_PRE;
          tx_cnt_nx   = '0;
        end
      end
      TX_PRE: begin
        byte_en  = 1'b1;
        byte_val = (tx_cnt == 8'd7) ? 8'hD5 : 8'h55;
        if (tx_cnt == 8'd7) begin
          tx_state_nx = TX_FRAME;
          tx_cnt_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt + 8'd1;
        end
      end
      TX_FRAME: begin
        byte_en  = 1'b1;
        byte_val = frame_vec[{frame_rev, 3'b000} +: 8];
        if (tx_cnt == 8'd59) begin
          tx_state_nx = TX_FCS;
          tx_cnt_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt + 8'd1;
        end
      end
      TX_FCS: begin
        byte_en  = 1'b1;
        byte_val = ~tx_crc[{tx_cnt[1:0], 3'b000} +: 8];
        if (tx_cnt == 8'd3) begin
          tx_state_nx = TX_IFG;
          tx_cnt_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt + 8'd1;
        end
      end
      TX_IFG: begin
        // Outputs lag the state by one register, so IFG_LAST+1 cycles here
        // give exactly IFG_CYCLES idle cycles on the wire before busy drops.
        if (tx_cnt == IFG_LAST) begin
          tx_state_nx = TX_IDLE;
          tx_done     = 1'b1;
        end else begin
          tx_cnt_nx = tx_cnt + 8'd1;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  // Reply fields are latched at accept so later RX frames cannot disturb them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_mac <= '0;
      tx_ip  <= '0;
      tx_crc <= '1;
    end else if (accept) begin
      tx_mac <= rx_sha;
      tx_ip  <= rx_spa;
      tx_crc <= '1;
    end else if (tx_state == TX_FRAME) begin
      tx_crc <= crc32_byte(tx_crc, byte_val);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_en   <= byte_en;
      tx_data <= byte_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_count     <= '0;
      reply_count   <= '0;
      drop_count    <= '0;
      crc_err_count <= '0;
    end else begin
      if (req_ok)  req_count     <= req_count + 16'd1;
      if (tx_done) reply_count   <= reply_count + 16'd1;
      if (drop)    drop_count    <= drop_count + 16'd1;
      if (crc_err) crc_err_count <= crc_err_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arp_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_responder
// Description : Self-checking bench for arp_responder. Expected reply bytes
//               are queued when a request is driven and popped as the DUT
//               transmits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_responder;

  localparam logic [47:0] MY_MAC   = 48'h00301ba0a48f;
  localparam logic [31:0] MY_IP    = 32'h0a001563;
  localparam logic [47:0] PEER_MAC = 48'h00301ba0a48e;
  localparam logic [31:0] PEER_IP  = 32'h0a00150a;
  localparam logic [47:0] BCAST    = 48'hffffffffffff;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx_dv   = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic [15:0] req_count, reply_count, drop_count, crc_err_count;

  arp_responder #(
    .MY_MAC    (MY_MAC),
    .MY_IP     (MY_IP),
    .IFG_CYCLES(12)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_dv        (rx_dv),
    .rx_data      (rx_data),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .busy         (busy),
    .req_count    (req_count),
    .reply_count  (reply_count),
    .drop_count   (drop_count),
    .crc_err_count(crc_err_count)
  );

  always #4 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tx_run  = 0;
  int          tx_seen = 0;
  logic [31:0] mon_crc = 32'hFFFFFFFF;
  logic [7:0]  sb[$];
  logic [7:0]  fr[$];
  logic [7:0]  txcap[0:79];

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmit monitor: compares every transmitted byte against the scoreboard.
  always @(negedge clock) begin
    if (!reset_n) begin
      tx_run = 0;
    end else if (tx_en) begin
      if (tx_run == 0) mon_crc = 32'hFFFFFFFF;
      if (tx_run >= 8) mon_crc = crc_step(mon_crc, tx_data);
      if (tx_run < 80) txcap[tx_run] = tx_data;
      tx_run++;
      tx_seen++;
      if (sb.size() == 0) check("tx_unexpected", 64'(tx_en), 64'd0);
      else                check("tx_byte", 64'(tx_data), 64'(sb.pop_front()));
    end else begin
      check("tx_idle_data", 64'(tx_data), 64'd0);
      if (tx_run != 0) begin
        check("tx_len", 64'(tx_run), 64'd72);
        check("tx_fcs_residue", 64'(mon_crc), 64'h00000000DEBB20E3);
        tx_run = 0;
      end
    end
  end

  task automatic add_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_step(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  // ARP request from PEER with given dst, ethertype and target IP.
  task automatic build_request(input logic [47:0] dst, input logic [15:0] etype,
                               input logic [31:0] tpa, input bit flip, input int len);
    fr.delete();
    add_be(dst, 6);
    add_be(PEER_MAC, 6);
    add_be(48'(etype), 2);
    add_be(48'h0001, 2);
    add_be(48'h0800, 2);
    add_be(48'h06, 1);
    add_be(48'h04, 1);
    add_be(48'h0001, 2);
    add_be(PEER_MAC, 6);
    add_be(48'(PEER_IP), 4);
    add_be(48'h0, 6);
    add_be(48'(tpa), 4);
    while (fr.size() < len) fr.push_back(8'h00);
    add_fcs();
    if (flip) fr[30] = fr[30] ^ 8'h04;
  endtask

  // Queue the expected reply (preamble, 60-byte frame, FCS) for sha/spa.
  task automatic expect_reply(input logic [47:0] sha, input logic [31:0] spa);
    logic [7:0] keep[$];
    keep = fr;
    fr.delete();
    add_be(sha, 6);
    add_be(MY_MAC, 6);
    add_be(48'h0806, 2);
    add_be(48'h0001, 2);
    add_be(48'h0800, 2);
    add_be(48'h06, 1);
    add_be(48'h04, 1);
    add_be(48'h0002, 2);
    add_be(MY_MAC, 6);
    add_be(48'(MY_IP), 4);
    add_be(sha, 6);
    add_be(48'(spa), 4);
    while (fr.size() < 60) fr.push_back(8'h00);
    add_fcs();
    for (int i = 0; i < 7; i++) sb.push_back(8'h55);
    sb.push_back(8'hD5);
    foreach (fr[i]) sb.push_back(fr[i]);
    fr = keep;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clock);
    rx_dv   = 1'b1;
    rx_data = b;
  endtask

  task automatic send_frame(input bit exp_reply, input logic [7:0] sfd, input bit peek_k);
    if (exp_reply) expect_reply(PEER_MAC, PEER_IP);
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(sfd);
    foreach (fr[i]) drive_byte(fr[i]);
    if (peek_k) begin
      @(posedge clock);
      #1 check("rx_k_saturate", 64'(dut.rx_k), 64'd2047);
    end
    @(negedge clock);
    rx_dv   = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic check_launch();
    @(posedge clock);
    #1;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("tx_en_not_early", 64'(tx_en), 64'd0);
    @(posedge clock);
    #1;
    check("tx_en_rise", 64'(tx_en), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy || tx_en || sb.size() != 0); i++) @(negedge clock);
    repeat (4) @(negedge clock);
    check("drain_done", 64'((sb.size() == 0) && !busy), 64'd1);
  endtask

  task automatic check_counts(input string tag, input int rq, input int rp, input int dr, input int ce);
    check({tag, "_req"},   64'(req_count),     64'(rq));
    check({tag, "_reply"}, 64'(reply_count),   64'(rp));
    check({tag, "_drop"},  64'(drop_count),    64'(dr));
    check({tag, "_crc"},   64'(crc_err_count), 64'(ce));
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clock);
    #1;
    sb.delete();
    tx_seen = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    check("reset_tx_en", 64'(tx_en), 64'd0);
    check("reset_tx_data", 64'(tx_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check_counts("reset", 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;

    // 1: broadcast request answered
    build_request(BCAST, 16'h0806, MY_IP, 1'b0, 60);
    send_frame(1'b1, 8'hD5, 1'b0);
    check_launch();
    wait_idle();
    check("t1_dst", {txcap[8], txcap[9], txcap[10], txcap[11], txcap[12], txcap[13]},
          64'(PEER_MAC));
    check("t1_oper", {txcap[28], txcap[29]}, 64'h0002);
    check("t1_tpa", {txcap[46], txcap[47], txcap[48], txcap[49]}, 64'(PEER_IP));
    check_counts("t1", 1, 1, 0, 0);

    // 2: one bit flipped -> FCS error, no reply
    do_reset();
    build_request(BCAST, 16'h0806, MY_IP, 1'b1, 60);
    send_frame(1'b0, 8'hD5, 1'b0);
    wait_idle();
    check_counts("t2", 0, 0, 0, 1);

    // 3: wrong target IP, wrong ethertype, wrong unicast dst -> ignored;
    //    unicast to MY_MAC -> answered
    do_reset();
    build_request(BCAST, 16'h0806, 32'h0a001562, 1'b0, 60);
    send_frame(1'b0, 8'hD5, 1'b0);
    build_request(BCAST, 16'h0800, MY_IP, 1'b0, 60);
    send_frame(1'b0, 8'hD5, 1'b0);
    build_request(48'h00301ba0a400, 16'h0806, MY_IP, 1'b0, 60);
    send_frame(1'b0, 8'hD5, 1'b0);
    wait_idle();
    check_counts("t3_ignored", 0, 0, 0, 0);
    build_request(MY_MAC, 16'h0806, MY_IP, 1'b0, 60);
    send_frame(1'b1, 8'hD5, 1'b0);
    wait_idle();
    check_counts("t3_unicast", 1, 1, 0, 0);

    // 4: second request while busy is dropped; gap 13 lands on the busy-fall
    //    cycle (still dropped), gap 14 is answered
    for (int g = 12; g <= 14; g++) begin
      do_reset();
      build_request(BCAST, 16'h0806, MY_IP, 1'b0, 60);
      send_frame(1'b1, 8'hD5, 1'b0);
      repeat (g - 1) @(negedge clock);
      send_frame(g == 14, 8'hD5, 1'b0);
      wait_idle();
      if (g == 14) check_counts("t4_gap14", 2, 2, 0, 0);
      else         check_counts("t4_busy", 2, 1, 1, 0);
    end

    // 5: runt, bad SFD, 3000-byte non-ARP frame with good FCS
    do_reset();
    build_request(BCAST, 16'h0806, MY_IP, 1'b0, 60);
    while (fr.size() > 40) void'(fr.pop_back());
    send_frame(1'b0, 8'hD5, 1'b0);
    build_request(BCAST, 16'h0806, MY_IP, 1'b0, 60);
    send_frame(1'b0, 8'h5D, 1'b0);
    build_request(BCAST, 16'h0800, MY_IP, 1'b0, 2996);
    send_frame(1'b0, 8'hD5, 1'b1);
    wait_idle();
    check_counts("t5", 0, 0, 0, 0);

    // 6: reset during transmission, then a normal request
    do_reset();
    build_request(BCAST, 16'h0806, MY_IP, 1'b0, 60);
    send_frame(1'b1, 8'hD5, 1'b0);
    check_launch();
    for (int i = 0; i < 200 && tx_seen < 30; i++) @(negedge clock);
    check("t6_reach_byte30", 64'(tx_seen >= 30), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_abort_tx_en", 64'(tx_en), 64'd0);
    check("t6_abort_busy", 64'(busy), 64'd0);
    check_counts("t6_abort", 0, 0, 0, 0);
    sb.delete();
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    tx_seen = 0;
    send_frame(1'b1, 8'hD5, 1'b0);
    check_launch();
    wait_idle();
    check_counts("t6_after", 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
